// File: rtl/diffusion_seq_pkg.sv
// rtl/diffusion_seq_pkg.sv - shared types and defaults for diffusion_step_sequencer
//
// Purpose : state encoding and default sizing shared by the sequencer,
//           its lane collectors and the bench.
// Ports   : none (package).
package diffusion_seq_pkg;

   localparam int STATE_W       = 3;
   localparam int DEF_PARALLEL  = 16;
   localparam int DEF_MAX_STEPS = 7;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_PROP  = 3'd1,
      ST_ADDUP = 3'd2,
      ST_ADV   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/lane_done_collector.sv
// rtl/lane_done_collector.sv - sticky per-lane completion mask
//
// Purpose : ORs per-lane finish pulses/levels into a sticky mask while
//           enabled, so lanes may finish in any order and on any cycle.
// Ports   : clk          clock, rising edge
//           rst_n        synchronous active-low reset
//           clr_i        clear the mask (wins over new hits)
//           en_i         collect lane_done_i this cycle
//           lane_done_i  per-lane finish indications
//           all_done_o   every lane has finished, counting this cycle's hits
module lane_done_collector #(
   parameter int PARALLEL = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic [PARALLEL-1:0] lane_done_i,
   output logic                all_done_o
);

   logic [PARALLEL-1:0] mask_q;
   logic [PARALLEL-1:0] mask_d;
   logic [PARALLEL-1:0] hits;

   always_comb begin
      hits   = en_i ? lane_done_i : '0;
      mask_d = mask_q | hits;
      if (clr_i) begin
         mask_d = '0;
      end
   end

   // Current-cycle hits count, so the phase can close on the same cycle
   // the last lane reports.
   assign all_done_o = &(mask_q | hits);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

endmodule

// File: rtl/diffusion_step_sequencer.sv
// rtl/diffusion_step_sequencer.sv - PROPAGATE/ADDUP phase sequencer for diffusion lanes
//
// Purpose : steps the random-walk lanes through PROPAGATE then ADDUP for
//           max_steps steps, issuing per-lane go pulses and phase levels.
// Macro   : STEP_TIMEOUT_EN enables the per-phase watchdog.
// Ports   : clk, rst_n             clock / synchronous active-low reset
//           start                  run request, honoured in IDLE or DONE
//           abort                  back to IDLE next cycle from any state
//           finished[P]            per-lane propagation finish
//           finished_final[P]      per-lane add-up finish
//           rdy[P]                 one-cycle go pulse on each PROP entry
//           l_step[DATA_WIDTH]     current step index
//           finished_propagation   high in ADDUP
//           finished_all           high in DONE
//           busy                   high in PROP, ADDUP or ADV
//           timeout_err            sticky watchdog flag
module diffusion_step_sequencer
   import diffusion_seq_pkg::*;
#(
   parameter int PARALLEL   = DEF_PARALLEL,
   parameter int DATA_WIDTH = 32,
   parameter int max_steps  = DEF_MAX_STEPS,
   parameter int TIMEOUT    = 1 << 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [PARALLEL-1:0]   finished,
   input  logic [PARALLEL-1:0]   finished_final,
   output logic [PARALLEL-1:0]   rdy,
   output logic [DATA_WIDTH-1:0] l_step,
   output logic                  finished_propagation,
   output logic                  finished_all,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam logic [DATA_WIDTH-1:0] LAST_STEP = DATA_WIDTH'(max_steps - 1);

   state_e                state_q, state_d;
   logic [PARALLEL-1:0]   rdy_q, rdy_d;
   logic [DATA_WIDTH-1:0] l_step_q, l_step_d;
   logic                  prop_all, fin_all;
   logic                  entering, clr_masks;
   logic                  timeout_hit;

`ifdef STEP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;

   always_comb begin
      timeout_hit   = ((state_q == ST_PROP) || (state_q == ST_ADDUP)) &&
                      (cnt_q == CNT_W'(TIMEOUT - 1));
      timeout_err_d = timeout_err_q | timeout_hit;
      // Counter restarts on every state change and idles outside the
      // two watched phases.
      if ((state_d != state_q) || !((state_d == ST_PROP) || (state_d == ST_ADDUP))) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start)    state_d = ST_PROP;
         ST_PROP:          if (prop_all) state_d = ST_ADDUP;
         ST_ADDUP:         if (fin_all)  state_d = (l_step_q == LAST_STEP) ? ST_DONE : ST_ADV;
         ST_ADV:                         state_d = ST_PROP;
         default:                        state_d = ST_IDLE;
      endcase
      if (timeout_hit) state_d = ST_IDLE;
      if (abort)       state_d = ST_IDLE;
   end

   always_comb begin
      entering  = (state_d != state_q);
      clr_masks = entering && ((state_d == ST_PROP) || (state_d == ST_IDLE));
      rdy_d     = (entering && (state_d == ST_PROP)) ? '1 : '0;
      l_step_d  = l_step_q;
      if ((state_q == ST_ADV) && (state_d == ST_PROP)) begin
         l_step_d = l_step_q + 1'b1;
      end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && (state_d == ST_PROP)) begin
         l_step_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rdy_q    <= '0;
         l_step_q <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         l_step_q <= l_step_d;
      end
   end

   // Each collector only listens during its own phase, so a level left
   // over from the other phase cannot close a phase early.
   lane_done_collector #(.PARALLEL(PARALLEL)) u_prop (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr_masks),
      .en_i        (state_q == ST_PROP),
      .lane_done_i (finished),
      .all_done_o  (prop_all)
   );

   lane_done_collector #(.PARALLEL(PARALLEL)) u_fin (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr_masks),
      .en_i        (state_q == ST_ADDUP),
      .lane_done_i (finished_final),
      .all_done_o  (fin_all)
   );

   // Phase levels decode the state register only: no input reaches an
   // output combinationally.
   assign rdy                  = rdy_q;
   assign l_step               = l_step_q;
   assign finished_propagation = (state_q == ST_ADDUP);
   assign finished_all         = (state_q == ST_DONE);
   assign busy                 = (state_q == ST_PROP) || (state_q == ST_ADDUP) ||
                                 (state_q == ST_ADV);

endmodule

// File: tb/tb_diffusion_step_sequencer.sv
// tb/tb_diffusion_step_sequencer.sv - directed self-checking bench for diffusion_step_sequencer
module tb_diffusion_step_sequencer;
   import diffusion_seq_pkg::*;

   localparam int P = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0;
   logic [P-1:0]  finished = '0, finished_final = '0;
   logic [P-1:0]  rdy;
   logic [31:0]   l_step;
   logic          fp, fa, busy, terr;

   logic          start1 = 1'b0, abort1 = 1'b0;
   logic [P-1:0]  fin1 = '0, ff1 = '0;
   logic [P-1:0]  rdy1;
   logic [31:0]   l_step1;
   logic          fp1, fa1, busy1, terr1;

   int n_cmp = 0;
   int n_err = 0;
   int rdy_cnt = 0;
   int perm [P];

   always #5 clk = ~clk;

   diffusion_step_sequencer #(
      .PARALLEL(P), .DATA_WIDTH(32), .max_steps(7), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .finished(finished), .finished_final(finished_final),
      .rdy(rdy), .l_step(l_step), .finished_propagation(fp),
      .finished_all(fa), .busy(busy), .timeout_err(terr)
   );

   diffusion_step_sequencer #(
      .PARALLEL(P), .DATA_WIDTH(32), .max_steps(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .finished(fin1), .finished_final(ff1),
      .rdy(rdy1), .l_step(l_step1), .finished_propagation(fp1),
      .finished_all(fa1), .busy(busy1), .timeout_err(terr1)
   );

   always @(negedge clk) begin
      if (rdy != '0) rdy_cnt = rdy_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shuffle();
      int j, t;
      for (int i = 0; i < P; i++) perm[i] = i;
      for (int i = P - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
   endtask

   // From the first cycle of PROP: whole-lane finish, whole-lane add-up,
   // ADV; lands on the first cycle of the next PROP.
   task automatic quick_step();
      finished = '1; tick(); finished = '0;
      finished_final = '1; tick(); finished_final = '0;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_rdy", 32'(rdy), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      // 1: reset in the middle of PROP at step 3
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) quick_step();
      check("t1_lstep3", l_step, 32'd3);
      finished = 16'h00FF; tick(); finished = '0;
      check("t1_partial_mask", 32'(dut.u_prop.mask_q), 32'h00FF);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t1_rdy", 32'(rdy), 32'h0);
      check("t1_lstep", l_step, 32'h0);
      check("t1_fp", 32'(fp), 32'h0);
      check("t1_fa", 32'(fa), 32'h0);
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_terr", 32'(terr), 32'h0);
      check("t1_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("t1_pmask", 32'(dut.u_prop.mask_q), 32'h0);
      check("t1_fmask", 32'(dut.u_fin.mask_q), 32'h0);

      // 2: full 7-step run, lanes in random order each phase
      rdy_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int s = 0; s < 7; s++) begin
         check("t2_rdy_go", 32'(rdy), 32'hFFFF);
         check("t2_lstep", l_step, 32'(s));
         shuffle();
         for (int k = 0; k < P; k++) begin
            finished = '0; finished[perm[k]] = 1'b1; tick();
            if (k == 0) check("t2_rdy_drop", 32'(rdy), 32'h0);
            if (k == P - 2) check("t2_prop_open", 32'(fp), 32'h0);
         end
         finished = '0;
         check("t2_fp", 32'(fp), 32'h1);
         shuffle();
         for (int k = 0; k < P; k++) begin
            finished_final = '0; finished_final[perm[k]] = 1'b1; tick();
         end
         finished_final = '0;
         if (s < 6) begin
            check("t2_adv_fp", 32'(fp), 32'h0);
            check("t2_adv_busy", 32'(busy), 32'h1);
            check("t2_adv_fa", 32'(fa), 32'h0);
            tick();
         end else begin
            check("t2_done_fa", 32'(fa), 32'h1);
            check("t2_done_busy", 32'(busy), 32'h0);
            check("t2_done_lstep", l_step, 32'd6);
         end
      end
      check("t2_rdy_cnt", 32'(rdy_cnt), 32'd7);

      // 3: lane 15 finishes 40 cycles after the rest
      start = 1'b1; tick(); start = 1'b0;
      check("t3_restart_rdy", 32'(rdy), 32'hFFFF);
      check("t3_restart_lstep", l_step, 32'h0);
      finished = 16'h7FFF; tick(); finished = '0;
      repeat (39) tick();
      check("t3_fp_early", 32'(fp), 32'h0);
      finished = 16'h8000; tick(); finished = '0;
      check("t3_fp_n41", 32'(fp), 32'h1);

      // 4: stale finished_final level from step 2 must not close step 3 ADDUP
      finished_final = '1; tick(); finished_final = '0;
      tick();
      quick_step();
      finished = '1; tick(); finished = '0;
      check("t4_addup2", l_step, 32'd2);
      finished_final = '1;
      tick(); tick();
      check("t4_prop3_lstep", l_step, 32'd3);
      check("t4_prop3_rdy", 32'(rdy), 32'hFFFF);
      tick();
      finished_final = '0;
      finished = '1; tick(); finished = '0;
      check("t4_addup3_fp", 32'(fp), 32'h1);
      repeat (5) tick();
      check("t4_addup3_wait", 32'(fp), 32'h1);
      check("t4_fmask_clear", 32'(dut.u_fin.mask_q), 32'h0);
      finished_final = '1; tick(); finished_final = '0;
      check("t4_adv_fp", 32'(fp), 32'h0);
      check("t4_adv_busy", 32'(busy), 32'h1);
      tick();
      check("t4_step4", l_step, 32'd4);
      start = 1'b1; tick(); start = 1'b0;
      check("t4_start_ignored_rdy", 32'(rdy), 32'h0);
      check("t4_start_ignored_lstep", l_step, 32'd4);

      // 5: abort from PROP; max_steps=1 run; abort beats start in DONE
      abort = 1'b1; tick(); abort = 1'b0;
      check("t5_abort_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("t5_abort_busy", 32'(busy), 32'h0);
      start1 = 1'b1; tick(); start1 = 1'b0;
      check("t5_ms1_rdy", 32'(rdy1), 32'hFFFF);
      fin1 = '1; tick(); fin1 = '0;
      check("t5_ms1_fp", 32'(fp1), 32'h1);
      ff1 = '1; tick(); ff1 = '0;
      check("t5_ms1_done", 32'(dut1.state_q), 32'(ST_DONE));
      check("t5_ms1_fa", 32'(fa1), 32'h1);
      check("t5_ms1_lstep", l_step1, 32'h0);
      start1 = 1'b1; abort1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
      check("t5_abort_win_state", 32'(dut1.state_q), 32'(ST_IDLE));
      check("t5_abort_win_rdy", 32'(rdy1), 32'h0);
      check("t5_abort_win_fa", 32'(fa1), 32'h0);

      // 6: lane 4 never finishes
      start = 1'b1; tick(); start = 1'b0;
      finished = 16'hFFEF;
      repeat (150) tick();
`ifdef STEP_TIMEOUT_EN
      check("t6_terr", 32'(terr), 32'h1);
      check("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
`else
      check("t6_terr", 32'(terr), 32'h0);
      check("t6_state", 32'(dut.state_q), 32'(ST_PROP));
      check("t6_fp", 32'(fp), 32'h0);
`endif
      finished = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
